// File: rtl/dino_jump.sv
// Jump physics: turns the up button into a per-frame vertical dino offset (yoff).
// Latency: yoff/state update one clk after the vsync falling edge; button adds 3 clks to arm a jump.
// No backpressure: presses while airborne or not running are dropped; halt freezes motion and drops ticks.
module dino_jump #(
  parameter int Y_W        = 10,
  parameter int V_W        = 6,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_HEIGHT = 120
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           vsync,
  input  logic           jump_btn,
  input  logic [1:0]     gs,
  input  logic           halt,
  input  logic           restart,
  output logic [Y_W-1:0] yoff,
  output logic           airborne,
  output logic           landed
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_state_t;

  localparam logic [1:0]   GS_RUNNING = 2'd1;
  localparam logic [V_W-1:0] VEL_LAUNCH = V_W'(JUMP_VEL);
  localparam logic [V_W-1:0] VEL_GRAV   = V_W'(GRAVITY);
  localparam logic [Y_W:0]   Y_CEIL     = (Y_W+1)'(MAX_HEIGHT);

  jump_state_t    state;
  logic [V_W-1:0] vel;

  // Button synchronizer and edge-detect history, plus the delayed vsync.
  logic btn_meta;
  logic btn_sync;
  logic btn_prev;
  logic vsync_d;

  logic jreq;
  logic tick;
  logic pending;

  // Next-height / next-velocity arithmetic, kept wide enough that the
  // ceiling compare and the saturation never see a wrapped value.
  logic [Y_W:0]   ny;
  logic [V_W:0]   nv_raw;
  logic [V_W-1:0] nv;
  logic           nv_lands;

  // Two-flop synchronizer for the raw button and frame-edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
      vsync_d  <= 1'b1;
    end else begin
      btn_meta <= jump_btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      vsync_d  <= vsync;
    end
  end

  // A press is only the rising edge, so a held button cannot retrigger.
  assign jreq = btn_sync & ~btn_prev;
  // vsync is active low; its falling edge marks the start of a frame.
  assign tick = vsync_d & ~vsync;

  // Rise step: add velocity at one extra bit so the ceiling compare is exact.
  assign ny = {1'b0, yoff} + (Y_W+1)'(vel);

  // Fall step: accelerate, saturating at the top of the velocity register.
  assign nv_raw   = {1'b0, vel} + (V_W+1)'(GRAVITY);
  assign nv       = nv_raw[V_W] ? {V_W{1'b1}} : nv_raw[V_W-1:0];
  assign nv_lands = (Y_W'(nv) >= yoff);

  // Jump request buffer: armed only on the ground while running; cleared when
  // the launch consumes it, or by halt/restart. Consumption outranks a new
  // request so a launch cannot leave a stale request behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
    end else if (restart || halt) begin
      pending <= 1'b0;
    end else if (tick && (state == GROUND) && pending) begin
      pending <= 1'b0;
    end else if (jreq && (state == GROUND) && (gs == GS_RUNNING)) begin
      pending <= 1'b1;
    end
  end

  // Per-frame motion FSM with registered height, velocity and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= GROUND;
      yoff     <= '0;
      vel      <= '0;
      airborne <= 1'b0;
      landed   <= 1'b0;
    end else begin
      landed <= 1'b0;
      if (restart) begin
        state    <= GROUND;
        yoff     <= '0;
        vel      <= '0;
        airborne <= 1'b0;
      end else if (!halt && tick) begin
        case (state)
          GROUND: begin
            if (pending) begin
              state    <= RISE;
              vel      <= VEL_LAUNCH;
              airborne <= 1'b1;
            end
          end
          RISE: begin
            if (ny >= Y_CEIL) begin
              yoff  <= Y_CEIL[Y_W-1:0];
              vel   <= '0;
              state <= FALL;
            end else if (vel <= VEL_GRAV) begin
              yoff  <= ny[Y_W-1:0];
              vel   <= '0;
              state <= FALL;
            end else begin
              yoff <= ny[Y_W-1:0];
              vel  <= vel - VEL_GRAV;
            end
          end
          FALL: begin
            if (nv_lands) begin
              yoff     <= '0;
              vel      <= '0;
              state    <= GROUND;
              airborne <= 1'b0;
              landed   <= 1'b1;
            end else begin
              yoff <= yoff - Y_W'(nv);
              vel  <= nv;
            end
          end
          default: begin
            state    <= GROUND;
            yoff     <= '0;
            vel      <= '0;
            airborne <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dino_jump.sv
// Directed bench for dino_jump: two instances (default ceiling and a 50-pixel
// ceiling) share stimulus; expected heights are queued per frame and popped
// after the frame edge has been applied.
module tb_dino_jump;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       jump_btn;
  logic [1:0] gs;
  logic       halt;
  logic       restart;

  logic [9:0] yoff;
  logic       airborne;
  logic       landed;
  logic [9:0] yoff_h50;
  logic       airborne_h50;
  logic       landed_h50;

  int checks   = 0;
  int failures = 0;
  int land_cnt = 0;
  int land50_cnt = 0;

  // Expected heights after each frame, starting with the launch frame.
  int jt   [25] = '{0, 12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
                    77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
  int jt50 [16] = '{0, 12, 23, 33, 42, 50, 49, 47, 44, 40, 35, 29, 22, 14, 5, 0};

  int exp_q[$];
  int exp50_q[$];

  dino_jump dut (
    .clk      (clk),
    .reset    (reset),
    .vsync    (vsync),
    .jump_btn (jump_btn),
    .gs       (gs),
    .halt     (halt),
    .restart  (restart),
    .yoff     (yoff),
    .airborne (airborne),
    .landed   (landed)
  );

  dino_jump #(.MAX_HEIGHT(50)) dut_h50 (
    .clk      (clk),
    .reset    (reset),
    .vsync    (vsync),
    .jump_btn (jump_btn),
    .gs       (gs),
    .halt     (halt),
    .restart  (restart),
    .yoff     (yoff_h50),
    .airborne (airborne_h50),
    .landed   (landed_h50)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (landed)     land_cnt++;
    if (landed_h50) land50_cnt++;
  end

  function automatic int exp_main(input int k);
    return (k < 25) ? jt[k] : 0;
  endfunction

  function automatic int exp_h50(input int k);
    return (k < 16) ? jt50[k] : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One video frame: vsync low for a clk, then idle time before sampling.
  task automatic frame();
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic step(input string tag, input int e, input int e50);
    exp_q.push_back(e);
    exp50_q.push_back(e50);
    frame();
    chk({tag, "_yoff"}, int'(yoff), exp_q.pop_front());
    chk({tag, "_yoff_h50"}, int'(yoff_h50), exp50_q.pop_front());
  endtask

  task automatic press();
    @(negedge clk) jump_btn = 1'b1;
    repeat (5) @(negedge clk);
    jump_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b0;
    vsync    = 1'b1;
    jump_btn = 1'b0;
    gs       = 2'd1;
    halt     = 1'b0;
    restart  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_yoff", int'(yoff), 0);
    chk("rst_airborne", int'(airborne), 0);
    chk("rst_landed", int'(landed), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Held button for 100 frames: one full jump, then stays on the ground.
    jump_btn = 1'b1;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      step("hold", exp_main(k), exp_h50(k));
      if (k == 0) chk("launch_airborne", int'(airborne), 1);
    end
    jump_btn = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_land_cnt", land_cnt, 1);
    chk("hold_land50_cnt", land50_cnt, 1);
    chk("hold_airborne", int'(airborne), 0);

    // Second press at the apex is dropped.
    press();
    for (int k = 0; k < 30; k++) begin
      step("apex", exp_main(k), exp_h50(k));
      if (k == 12) begin
        chk("apex_airborne", int'(airborne), 1);
        press();
      end
    end
    chk("apex_land_cnt", land_cnt, 2);

    // Halt at yoff=50 for 10 frames, then resume.
    press();
    for (int k = 0; k < 6; k++) step("pre_halt", exp_main(k), exp_h50(k));
    halt = 1'b1;
    for (int k = 0; k < 10; k++) step("halted", 50, 50);
    chk("halt_landed", int'(landed), 0);
    halt = 1'b0;
    step("resume", exp_main(6), exp_h50(6));
    step("resume", exp_main(7), exp_h50(7));

    // Restart while halted at yoff=63.
    halt = 1'b1;
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    chk("restart_yoff", int'(yoff), 0);
    chk("restart_airborne", int'(airborne), 0);
    chk("restart_yoff_h50", int'(yoff_h50), 0);
    halt = 1'b0;
    for (int k = 0; k < 3; k++) step("post_restart", 0, 0);
    chk("restart_land_cnt", land_cnt, 2);

    // New jump after restart, then asynchronous reset mid-jump.
    press();
    for (int k = 0; k < 4; k++) step("rejump", exp_main(k), exp_h50(k));
    @(negedge clk) reset = 1'b0;
    #1;
    chk("areset_yoff", int'(yoff), 0);
    chk("areset_airborne", int'(airborne), 0);
    chk("areset_yoff_h50", int'(yoff_h50), 0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    // Not running: presses ignored.
    gs = 2'd0;
    press();
    for (int k = 0; k < 4; k++) step("gs0", 0, 0);
    chk("gs0_airborne", int'(airborne), 0);
    gs = 2'd2;
    press();
    for (int k = 0; k < 4; k++) step("gs2", 0, 0);
    chk("gs2_airborne", int'(airborne), 0);

    // Jump in flight completes after game over.
    gs = 2'd1;
    press();
    for (int k = 0; k < 30; k++) begin
      if (k == 3) gs = 2'd2;
      step("flight_over", exp_main(k), exp_h50(k));
    end
    chk("final_land_cnt", land_cnt, 3);
    chk("final_land50_cnt", land50_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
